// File: rtl/id_scoreboard_if.sv
// Bundle of the scoreboard's decode-side signals: issue, retire, kill,
// source read ports, forwarding taps and the resulting operands/stall.
interface id_scoreboard_if #(
   parameter int NREG = 32,
   parameter int DW   = 32,
   parameter int NRD  = 2,
   parameter int NFWD = 3
);
   localparam int AW = $clog2(NREG);

   // issue
   logic                iss_valid;
   logic                iss_we;
   logic [AW-1:0]       iss_dest;
   logic                iss_ready;
   // retire / kill
   logic                ret_valid;
   logic [AW-1:0]       ret_dest;
   logic                kill_valid;
   logic [AW-1:0]       kill_dest;
   // source read ports
   logic [NRD-1:0]      rd_need;
   logic [NRD*AW-1:0]   rd_addr;
   logic [NRD*DW-1:0]   rf_rdata;
   logic [NRD*DW-1:0]   rd_data;
   logic                rd_stall;
   // forwarding stages, index 0 youngest
   logic [NFWD-1:0]     fwd_valid;
   logic [NFWD-1:0]     fwd_we;
   logic [NFWD-1:0]     fwd_ready;
   logic [NFWD*AW-1:0]  fwd_dest;
   logic [NFWD*DW-1:0]  fwd_data;
   // status
   logic                sb_err;

   modport master (
      output iss_valid, iss_we, iss_dest, ret_valid, ret_dest, kill_valid, kill_dest,
             rd_need, rd_addr, rf_rdata, fwd_valid, fwd_we, fwd_ready, fwd_dest, fwd_data,
      input  iss_ready, rd_data, rd_stall, sb_err
   );

   modport slave (
      input  iss_valid, iss_we, iss_dest, ret_valid, ret_dest, kill_valid, kill_dest,
             rd_need, rd_addr, rf_rdata, fwd_valid, fwd_we, fwd_ready, fwd_dest, fwd_data,
      output iss_ready, rd_data, rd_stall, sb_err
   );
endinterface

// File: rtl/id_scoreboard.sv
// Register scoreboard for the decode stage: counts in-flight writers per
// architectural register, resolves operands through the forwarding network
// and raises a stall while a needed source is not yet available.
module id_scoreboard #(
   parameter int NREG  = 32,
   parameter int DW    = 32,
   parameter int NRD   = 2,
   parameter int NFWD  = 3,
   parameter int CNT_W = 2
) (
   input  logic         clk,
   input  logic         resetn,
   id_scoreboard_if.slave sb
);
   localparam int AW = $clog2(NREG);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [CNT_W-1:0] cnt_q [NREG];
   logic [CNT_W-1:0] cnt_d [NREG];
   logic             err_q;
   logic             err_d;
   logic             iss_fire;

   assign sb.sb_err = err_q;

   // Issue acceptance: only a saturated destination with no same-cycle release blocks issue.
   always_comb begin
      logic iss_tracked;
      logic dest_freed;
      iss_tracked = sb.iss_we && (sb.iss_dest != '0);
      dest_freed  = (sb.ret_valid  && (sb.ret_dest  == sb.iss_dest)) ||
                    (sb.kill_valid && (sb.kill_dest == sb.iss_dest));
      sb.iss_ready = !(iss_tracked && (cnt_q[sb.iss_dest] == CNT_MAX) && !dest_freed);
      iss_fire     = sb.iss_valid && sb.iss_ready && iss_tracked;
   end

   // Next counter values: issue/retire/kill on one register sum, clamped at zero.
   always_comb begin
      int v;
      // NOTE: every output of a combinational block gets a value on every path
      // (defaults first), otherwise synthesis infers a latch.
      err_d    = err_q;
      cnt_d[0] = '0;
      for (int r = 1; r < NREG; r++) begin
         v = int'(cnt_q[r]);
         if (iss_fire && (sb.iss_dest == AW'(r)))       v = v + 1;
         if (sb.ret_valid && (sb.ret_dest == AW'(r)))   v = v - 1;
         if (sb.kill_valid && (sb.kill_dest == AW'(r))) v = v - 1;
         if (v < 0) begin
            v     = 0;
            err_d = 1'b1;
         end
         cnt_d[r] = CNT_W'(v);
      end
   end

   // Counter and sticky error state; synchronous active-low reset wins over all events.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples
      // the pre-edge values; the counters are plain flops, so they are reset
      // explicitly rather than treated as an uninitialised memory.
      if (!resetn) begin
         for (int r = 0; r < NREG; r++) cnt_q[r] <= '0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end

   // Operand resolution and stall: youngest matching forwarding stage wins, r0 reads as zero.
   always_comb begin
      logic [AW-1:0] addr;
      logic          hit;
      logic          hit_rdy;
      logic [DW-1:0] hit_data;
      sb.rd_data  = '0;
      sb.rd_stall = 1'b0;
      for (int p = 0; p < NRD; p++) begin
         addr     = sb.rd_addr[p*AW +: AW];
         hit      = 1'b0;
         hit_rdy  = 1'b0;
         hit_data = '0;
         // Walk oldest to youngest so the youngest match overwrites older ones.
         for (int i = NFWD - 1; i >= 0; i--) begin
            if (sb.fwd_valid[i] && sb.fwd_we[i] && (sb.fwd_dest[i*AW +: AW] == addr)) begin
               hit      = 1'b1;
               hit_rdy  = sb.fwd_ready[i];
               hit_data = sb.fwd_data[i*DW +: DW];
            end
         end
         if (addr != '0) begin
            sb.rd_data[p*DW +: DW] = hit ? hit_data : sb.rf_rdata[p*DW +: DW];
            if (sb.rd_need[p] && (hit ? !hit_rdy : (cnt_q[addr] != '0)))
               sb.rd_stall = 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_id_scoreboard.sv
// Self-checking bench for id_scoreboard: directed scenarios followed by
// randomized traffic, all compared against an event-level reference model.
module tb_id_scoreboard;
   localparam int NREG  = 32;
   localparam int DW    = 32;
   localparam int NRD   = 2;
   localparam int NFWD  = 3;
   localparam int CNT_W = 2;
   localparam int AW    = $clog2(NREG);
   localparam int MAXC  = (1 << CNT_W) - 1;

   logic clk = 1'b0;
   logic resetn;

   id_scoreboard_if #(.NREG(NREG), .DW(DW), .NRD(NRD), .NFWD(NFWD)) sb ();

   id_scoreboard #(.NREG(NREG), .DW(DW), .NRD(NRD), .NFWD(NFWD), .CNT_W(CNT_W)) dut (
      .clk   (clk),
      .resetn(resetn),
      .sb    (sb)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // reference model: in-flight writers per register and the sticky error
   int cnt_m [NREG];
   bit err_m;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic clear_inputs();
      sb.iss_valid = 0; sb.iss_we = 0; sb.iss_dest = '0;
      sb.ret_valid = 0; sb.ret_dest = '0;
      sb.kill_valid = 0; sb.kill_dest = '0;
      sb.rd_need = '0; sb.rd_addr = '0; sb.rf_rdata = '0;
      sb.fwd_valid = '0; sb.fwd_we = '0; sb.fwd_ready = '0;
      sb.fwd_dest = '0; sb.fwd_data = '0;
   endtask

   function automatic bit exp_ready();
      int d;
      d = int'(sb.iss_dest);
      if (!sb.iss_we || d == 0) return 1'b1;
      if (cnt_m[d] < MAXC) return 1'b1;
      if (sb.ret_valid && int'(sb.ret_dest) == d) return 1'b1;
      if (sb.kill_valid && int'(sb.kill_dest) == d) return 1'b1;
      return 1'b0;
   endfunction

   task automatic check_outputs(input string tag);
      int a;
      int hit;
      bit stall_e;
      logic [DW-1:0] data_e;
      stall_e = 0;
      for (int p = 0; p < NRD; p++) begin
         a   = int'(sb.rd_addr[p*AW +: AW]);
         hit = -1;
         for (int i = 0; i < NFWD; i++)
            if (hit < 0 && sb.fwd_valid[i] && sb.fwd_we[i] && int'(sb.fwd_dest[i*AW +: AW]) == a)
               hit = i;
         if (a == 0)        data_e = '0;
         else if (hit >= 0) data_e = sb.fwd_data[hit*DW +: DW];
         else               data_e = sb.rf_rdata[p*DW +: DW];
         check($sformatf("%s_rd_data%0d", tag, p), 64'(sb.rd_data[p*DW +: DW]), 64'(data_e));
         if (sb.rd_need[p] && a != 0) begin
            if (hit >= 0) begin
               if (!sb.fwd_ready[hit]) stall_e = 1;
            end else if (cnt_m[a] != 0) stall_e = 1;
         end
      end
      check({tag, "_rd_stall"}, 64'(sb.rd_stall), 64'(stall_e));
      check({tag, "_iss_ready"}, 64'(sb.iss_ready), 64'(exp_ready()));
      check({tag, "_sb_err"}, 64'(sb.sb_err), 64'(err_m));
   endtask

   // Inputs are set at the falling edge; check, then advance the model across the rising edge.
   task automatic cycle(input string tag);
      int nxt [NREG];
      bit nerr;
      bit fire;
      #1;
      check_outputs(tag);
      fire = sb.iss_valid && exp_ready() && sb.iss_we && sb.iss_dest != 0;
      nxt  = cnt_m;
      nerr = err_m;
      if (fire) nxt[sb.iss_dest] += 1;
      if (sb.ret_valid && sb.ret_dest != 0) nxt[sb.ret_dest] -= 1;
      if (sb.kill_valid && sb.kill_dest != 0) nxt[sb.kill_dest] -= 1;
      foreach (nxt[r]) if (nxt[r] < 0) begin nxt[r] = 0; nerr = 1; end
      @(posedge clk);
      if (!resetn) begin
         foreach (cnt_m[r]) cnt_m[r] = 0;
         err_m = 0;
      end else begin
         cnt_m = nxt;
         err_m = nerr;
      end
      @(negedge clk);
   endtask

   task automatic issue(input int d);
      clear_inputs();
      sb.iss_valid = 1; sb.iss_we = 1; sb.iss_dest = AW'(d);
   endtask

   initial begin
      foreach (cnt_m[r]) cnt_m[r] = 0;
      err_m  = 1'b1;   // unknown until the first reset edge
      resetn = 1'b0;
      clear_inputs();
      @(negedge clk);
      err_m = 1'b0;
      cycle("reset0");
      cycle("reset1");
      check("reset_iss_ready", 64'(sb.iss_ready), 64'd1);
      check("reset_rd_stall", 64'(sb.rd_stall), 64'd0);
      resetn = 1'b1;

      // issue r5, then read r5 -> stall until the retire has been registered
      issue(5);
      cycle("r5_issue");
      clear_inputs();
      sb.rd_need[0] = 1; sb.rd_addr[0 +: AW] = AW'(5);
      #1 check("r5_pending_stall", 64'(sb.rd_stall), 64'd1);
      sb.ret_valid = 1; sb.ret_dest = AW'(5);
      cycle("r5_retire");
      sb.ret_valid = 0;
      #1 check("r5_after_ret_stall", 64'(sb.rd_stall), 64'd0);
      cycle("r5_clear");

      // two stages writing r7: youngest wins; not-ready youngest stalls
      clear_inputs();
      sb.fwd_valid = 3'b101; sb.fwd_we = 3'b101; sb.fwd_ready = 3'b101;
      sb.fwd_dest[0 +: AW] = AW'(7); sb.fwd_dest[2*AW +: AW] = AW'(7);
      sb.fwd_data[0 +: DW] = 32'h11; sb.fwd_data[2*DW +: DW] = 32'h22;
      sb.rd_need[0] = 1; sb.rd_addr[0 +: AW] = AW'(7); sb.rf_rdata[0 +: DW] = 32'hdead;
      #1 check("r7_fwd_youngest", 64'(sb.rd_data[0 +: DW]), 64'h11);
      cycle("r7_fwd");
      sb.fwd_ready[0] = 0;
      #1 check("r7_notready_stall", 64'(sb.rd_stall), 64'd1);
      cycle("r7_notready");

      // saturate r3, then release in the same cycle as a fourth issue
      for (int k = 0; k < 3; k++) begin issue(3); cycle("r3_fill"); end
      issue(3);
      #1 check("r3_full_ready", 64'(sb.iss_ready), 64'd0);
      cycle("r3_full");
      sb.ret_valid = 1; sb.ret_dest = AW'(3);
      #1 check("r3_ret_ready", 64'(sb.iss_ready), 64'd1);
      cycle("r3_issue_ret");
      issue(3);
      #1 check("r3_still_full", 64'(sb.iss_ready), 64'd0);
      cycle("r3_still_full");
      clear_inputs();
      sb.ret_valid = 1; sb.ret_dest = AW'(3);
      for (int k = 0; k < 3; k++) cycle("r3_drain");

      // retire + kill on r9 with one writer in flight -> underflow, sticky error
      issue(9);
      cycle("r9_issue");
      clear_inputs();
      sb.ret_valid = 1; sb.ret_dest = AW'(9);
      sb.kill_valid = 1; sb.kill_dest = AW'(9);
      cycle("r9_underflow");
      clear_inputs();
      sb.rd_need[0] = 1; sb.rd_addr[0 +: AW] = AW'(9);
      #1 check("r9_err_set", 64'(sb.sb_err), 64'd1);
      check("r9_cnt_zero_stall", 64'(sb.rd_stall), 64'd0);
      for (int k = 0; k < 3; k++) cycle("r9_sticky");
      resetn = 0;
      cycle("r9_reset");
      resetn = 1;
      #1 check("r9_err_cleared", 64'(sb.sb_err), 64'd0);
      cycle("r9_after_reset");

      // r0: forwarded writes ignored, reads zero, issue to r0 never tracked
      clear_inputs();
      sb.fwd_valid[0] = 1; sb.fwd_we[0] = 1; sb.fwd_ready[0] = 0;
      sb.fwd_dest[0 +: AW] = '0; sb.fwd_data[0 +: DW] = 32'hffff;
      sb.rd_need = '1; sb.rf_rdata = '1;
      sb.iss_valid = 1; sb.iss_we = 1; sb.iss_dest = '0;
      #1 check("r0_rd_data", 64'(sb.rd_data[0 +: DW]), 64'd0);
      check("r0_rd_stall", 64'(sb.rd_stall), 64'd0);
      cycle("r0_access");
      cycle("r0_again");

      // randomized traffic on a small register window to force collisions
      for (int n = 0; n < 3000; n++) begin
         resetn        = ($urandom_range(0, 99) != 0);
         sb.iss_valid  = $urandom_range(0, 1);
         sb.iss_we     = ($urandom_range(0, 3) != 0);
         sb.iss_dest   = AW'($urandom_range(0, 7));
         sb.ret_valid  = ($urandom_range(0, 2) == 0);
         sb.ret_dest   = AW'($urandom_range(0, 7));
         sb.kill_valid = ($urandom_range(0, 7) == 0);
         sb.kill_dest  = AW'($urandom_range(0, 7));
         sb.rd_need    = NRD'($urandom);
         for (int p = 0; p < NRD; p++) begin
            sb.rd_addr[p*AW +: AW]  = AW'($urandom_range(0, 7));
            sb.rf_rdata[p*DW +: DW] = $urandom;
         end
         sb.fwd_valid = NFWD'($urandom);
         sb.fwd_we    = NFWD'($urandom);
         sb.fwd_ready = NFWD'($urandom);
         for (int i = 0; i < NFWD; i++) begin
            sb.fwd_dest[i*AW +: AW]  = AW'($urandom_range(0, 7));
            sb.fwd_data[i*DW +: DW]  = $urandom;
         end
         cycle("rand");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/id_scoreboard.md
ID_SCOREBOARD -- requirements
Module: id_scoreboard

Interface
REQ-001 SHALL have parameter NREG, default 32: number of architectural registers; AW = clog2(NREG).
REQ-002 SHALL have parameter DW, default 32: register data width.
REQ-003 SHALL have parameter NRD, default 2: number of source read ports.
REQ-004 SHALL have parameter NFWD, default 3: number of forwarding stages; index 0 is the youngest (EX), NFWD-1 the oldest (WB).
REQ-005 SHALL have parameter CNT_W, default 2: per-register in-flight counter width; MAX = 2^CNT_W-1.
REQ-006 clk  in  1  single clock; all state updates on posedge.
REQ-007 resetn  in  1  reset, synchronous, active-low.
REQ-008 iss_valid / iss_we  in  1 / 1  issue attempt from decode / issued instruction writes a register.
REQ-009 iss_dest  in  AW  destination register of the issuing instruction.
REQ-010 iss_ready  out  1  issue accepted this cycle.
REQ-011 ret_valid / ret_dest  in  1 / AW  writing instruction retired at write-back.
REQ-012 kill_valid / kill_dest  in  1 / AW  in-flight writing instruction cancelled without write-back.
REQ-013 rd_need / rd_addr  in  NRD / NRD*AW  per-port source used / source register number.
REQ-014 rf_rdata  in  NRD*DW  register-file read data per port.
REQ-015 fwd_valid / fwd_we / fwd_ready  in  NFWD each  stage holds an instruction / it writes a register / its result is available.
REQ-016 fwd_dest / fwd_data  in  NFWD*AW / NFWD*DW  per-stage destination and result.
REQ-017 rd_data  out  NRD*DW  resolved operand per port.
REQ-018 rd_stall  out  1  decode must hold.
REQ-019 sb_err  out  1  sticky counter-underflow flag.

Function
REQ-020 SHALL hold one CNT_W-bit counter per register 1..NREG-1; register 0 is never tracked, never stalls, and reads as 0 on rd_data.
REQ-021 Issue fire = iss_valid & iss_ready & iss_we & (iss_dest != 0); fire increments cnt[iss_dest] at the next edge.
REQ-022 iss_ready SHALL be 0 only when iss_we & iss_dest != 0 & cnt[iss_dest] == MAX & no same-cycle ret_valid or kill_valid to iss_dest; otherwise 1; iss_ready does not depend on rd_stall.
REQ-023 ret_valid (ret_dest != 0) and kill_valid (kill_dest != 0) each decrement their counter by 1 at the next edge.
REQ-024 Simultaneous events on one register SHALL sum: issue+retire -> unchanged; retire+kill -> -2; issue+retire+kill -> -1.
REQ-025 A decrement that would go below 0 SHALL leave the counter at 0 and set sb_err, which stays 1 until reset.
REQ-026 Per port p, forward hit = youngest stage i with fwd_valid[i] & fwd_we[i] & fwd_dest[i] == rd_addr[p] != 0.
REQ-027 rd_data[p] SHALL be: 0 if rd_addr[p] == 0; else fwd_data of the hit stage if any; else rf_rdata[p]; combinational, no latency.
REQ-028 Port p stalls if rd_need[p] & rd_addr[p] != 0 & (hit stage has fwd_ready = 0, or no hit and cnt[rd_addr[p]] != 0).
REQ-029 rd_stall SHALL be the OR of all per-port stalls; a port with rd_need = 0 never stalls.
REQ-030 Counters SHALL reflect only prior-cycle events; a same-cycle issue does not affect rd_stall.

Reset
REQ-031 resetn = 0 at a clock edge SHALL clear all counters and sb_err regardless of any other input, including mid-operation.
REQ-032 During and after reset, with no inputs active: iss_ready = 1, rd_stall = 0, sb_err = 0.

Verification
REQ-033 Issue r5 write, next cycle rd_need[0]=1, rd_addr[0]=5, no fwd hit -> rd_stall = 1; ret r5 -> following cycle rd_stall = 0.
REQ-034 fwd stage0 and stage2 both write r7 (data 0x11 / 0x22, ready) -> rd_data = 0x11; stage0 fwd_ready = 0 -> rd_stall = 1.
REQ-035 CNT_W=2: issue r3 three times -> iss_ready = 0 for a fourth r3 write; same cycle ret r3 -> iss_ready = 1, counter stays 3.
REQ-036 ret_valid and kill_valid on r9 with cnt = 1 -> cnt = 0, sb_err = 1 and stays set; resetn low one cycle -> sb_err = 0.
REQ-037 rd_addr = 0 with stage0 writing r0 (data 0xFFFF) -> rd_data = 0, rd_stall = 0, counters unchanged.
